debug_memory_dumper: RTL

- Debug-side initiator for the data memory access block's debug port.
- On `start`, takes over data memory: asserts `debugMode`, walks word addresses 0..WORDS-1 on `DebugAddress`, and generates one `debugClk` pulse per word.
- Captures each 32-bit read word and streams it out MSB-byte-first over a byte-wide valid/ready interface to the UART transmitter.
- Sits between the pipeline's data memory access block and the debug UART TX.

---
 rtl/debug_memory_dumper.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/debug_memory_dumper.sv
// Debug-side initiator: takes over data memory through its debug port, reads
// words 0..WORDS-1 and streams each one MSB-byte-first to the UART transmitter.
module debug_memory_dumper #(
    parameter int Width_B = 32,
    parameter int Addr_B  = 32,
    parameter int WORDS   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [Width_B-1:0] ReadData,
    output logic               debugMode,
    output logic               debugClk,
    output logic [Addr_B-1:0]  DebugAddress,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done
);

    localparam int BYTES = Width_B / 8;
    localparam int CNT_B = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_B = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_B-1:0] LAST_BYTE = CNT_B'(BYTES - 1);
    localparam logic [IDX_B-1:0] LAST_WORD = IDX_B'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CLK_HI,
        CLK_LO,
        SEND,
        NEXT
    } dumpState;

    dumpState           state;
    dumpState           stateNxt;
    logic [IDX_B-1:0]   wordIdx;
    logic [IDX_B-1:0]   wordIdxNxt;
    logic [CNT_B-1:0]   byteCnt;
    logic [CNT_B-1:0]   byteCntNxt;
    logic [Width_B-1:0] captureReg;
    logic [Width_B-1:0] captureNxt;
    logic [Width_B-1:0] shifted;
    logic [7:0]         txDataNxt;
    logic               txValidNxt;
    logic               debugClkNxt;
    logic               doneNxt;
    logic               abortFlag;
    logic               abortFlagNxt;
    logic               abortReq;
    logic               transfer;
    logic               lastByte;
    logic               lastWord;

    // The word index is the only live part of the address; upper bits stay zero.
    assign DebugAddress = Addr_B'(wordIdx);

    assign abortReq = abort | abortFlag;
    assign transfer = tx_valid & tx_ready;
    assign lastByte = (byteCnt == LAST_BYTE);
    assign lastWord = (wordIdx == LAST_WORD);
    assign shifted  = captureReg << 8;

    // NOTE: all state and output registers use non-blocking assignments so
    // every one of them is computed from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wordIdx    <= '0;
            byteCnt    <= '0;
            captureReg <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            debugClk   <= 1'b0;
            debugMode  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            abortFlag  <= 1'b0;
        end else begin
            state      <= stateNxt;
            wordIdx    <= wordIdxNxt;
            byteCnt    <= byteCntNxt;
            captureReg <= captureNxt;
            tx_data    <= txDataNxt;
            tx_valid   <= txValidNxt;
            debugClk   <= debugClkNxt;
            debugMode  <= (stateNxt != IDLE);
            busy       <= (stateNxt != IDLE);
            done       <= doneNxt;
            abortFlag  <= abortFlagNxt;
        end
    end

    // Abort is honoured immediately outside SEND; inside SEND only on a
    // transfer edge so the presented byte is never withdrawn.
    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (start) stateNxt = ADDR;
            ADDR:    stateNxt = abortReq ? IDLE : CLK_HI;
            CLK_HI:  stateNxt = abortReq ? IDLE : CLK_LO;
            CLK_LO:  stateNxt = abortReq ? IDLE : SEND;
            SEND: begin
                if (transfer) begin
                    if (abortReq)      stateNxt = IDLE;
                    else if (lastByte) stateNxt = NEXT;
                end
            end
            NEXT:    stateNxt = (abortReq || lastWord) ? IDLE : ADDR;
            default: stateNxt = IDLE;
        endcase
    end

    // NOTE: every signal gets a hold/idle default before the case so that no
    // path through this block can infer a latch.
    always_comb begin
        wordIdxNxt   = wordIdx;
        byteCntNxt   = byteCnt;
        captureNxt   = captureReg;
        txDataNxt    = tx_data;
        txValidNxt   = tx_valid;
        debugClkNxt  = (stateNxt == CLK_HI);
        doneNxt      = (state != IDLE) && (stateNxt == IDLE);
        abortFlagNxt = abortFlag;

        if (stateNxt == IDLE)
            abortFlagNxt = 1'b0;
        else if ((state != IDLE) && abort)
            abortFlagNxt = 1'b1;

        unique case (state)
            IDLE: begin
                if (start) wordIdxNxt = '0;
            end
            CLK_LO: begin
                // Memory sampled on the debugClk falling edge; word is settled now.
                if (stateNxt == SEND) begin
                    captureNxt = ReadData;
                    byteCntNxt = '0;
                    txDataNxt  = ReadData[Width_B-1 -: 8];
                    txValidNxt = 1'b1;
                end
            end
            SEND: begin
                if (transfer) begin
                    if (stateNxt == SEND) begin
                        captureNxt = shifted;
                        byteCntNxt = byteCnt + CNT_B'(1);
                        txDataNxt  = shifted[Width_B-1 -: 8];
                    end else begin
                        txValidNxt = 1'b0;
                    end
                end
            end
            NEXT: begin
                if (stateNxt == ADDR) wordIdxNxt = wordIdx + IDX_B'(1);
            end
            default: ;
        endcase
    end

endmodule
